// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
// Holds the FSM state encoding, the geometry check and the chunk-index width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= 2) && (width % chunk == 0);
    endfunction

    // Index width is never allowed to collapse to zero bits for a single chunk.
    function automatic int idx_width(input int nchunk);
        return (nchunk <= 2) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full_adder cells.
// Purely combinational: zero latency, no backpressure.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    // Each stage owns its own carry nets so the chain is not one self-feeding vector.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (ci),
            .s  (sum[i]),
            .co (co)
        );
    end

    assign cout  = g_bit[CHUNK-1].co;
    assign c_msb = g_bit[CHUNK-1].ci;
endmodule

// File: rtl/chunk_serial_adder.sv
// Purpose: WIDTH-bit add (A-B when ADDER_SUB_EN is defined), CHUNK bits per cycle, (WIDTH+1)-bit result.
// Latency: WIDTH/CHUNK cycles from the acceptance edge to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module chunk_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             out_carry,
    output logic             out_ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("chunk_serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t         state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic           carry_q, carry_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [WIDTH:0] out_q, out_d;
    logic           cflag_q, cflag_d;
    logic           ovf_q, ovf_d;

    logic [WIDTH-1:0] b_in;
    logic             cin_in;

`ifdef ADDER_SUB_EN
    assign b_in   = in_sub ? ~in_b : in_b;
    assign cin_in = in_sub;
`else
    logic unused_sub;
    assign unused_sub = in_sub;
    assign b_in       = in_b;
    assign cin_in     = 1'b0;
`endif

    logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
    logic             cout, c_msb;

    assign a_sl = a_q[idx_q*CHUNK +: CHUNK];
    assign b_sl = b_q[idx_q*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_sl),
        .b     (b_sl),
        .cin   (carry_q),
        .sum   (sum_sl),
        .cout  (cout),
        .c_msb (c_msb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        out_d   = out_q;
        cflag_d = cflag_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = b_in;
                    carry_d = cin_in;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                out_d[idx_q*CHUNK +: CHUNK] = sum_sl;
                carry_d = cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Sign bit of the widened result and flags come from the top chunk only.
                    out_d[WIDTH] = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ cout;
                    cflag_d      = cout;
                    ovf_d        = cout ^ c_msb;
                    idx_d        = '0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            out_q   <= '0;
            cflag_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            cflag_q <= cflag_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign out_carry = cflag_q;
    assign out_ovf   = ovf_q;

endmodule
